// File: rtl/unit_control_mc.sv
// unit_control_mc -- multi-cycle instruction control unit.
//
// Walks each instruction through IF -> ID -> EX -> (MEM) -> WB and drives the
// datapath controls for the current phase. HALT is entered on an all-ones
// instruction class and is left only by reset.
//
// Ports
//   CLK, RESET_N        clock (rising edge), asynchronous active-low reset
//   instr_type [TYPEW]  instruction class ("type" is a reserved word in SV)
//   op [OPW]            instruction opcode
//   IM_READY, DM_READY  instruction / data memory done
//   STALL               freeze request (ignored in HALT)
//   TAKEN               branch flag-test result, sampled on leaving EX
//   OP_ALU, OP_TF, OP_SE, S_MXSE   EX-phase datapath controls (held after EX)
//   S_MXRB, S_MXPC                 WB-phase datapath selects (held after WB)
//   W_IM, W_DM, W_RB, W_PC, W_RF   write strobes, live only in their own state
//   STATE_O, HALTED                current state code, high in HALT
module unit_control_mc #(
    parameter int              OPW      = 5,
    parameter int              TYPEW    = 3,
    parameter logic [OPW-1:0]  ALU_PASS = OPW'(5'b10011)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [TYPEW-1:0] instr_type,
    input  logic [OPW-1:0]   op,
    input  logic             IM_READY,
    input  logic             DM_READY,
    input  logic             STALL,
    input  logic             TAKEN,
    output logic [OPW-1:0]   OP_ALU,
    output logic [2:0]       OP_TF,
    output logic             OP_SE,
    output logic             S_MXSE,
    output logic [1:0]       S_MXRB,
    output logic             S_MXPC,
    output logic             W_IM,
    output logic             W_DM,
    output logic             W_RB,
    output logic             W_PC,
    output logic [2:0]       W_RF,
    output logic [2:0]       STATE_O,
    output logic             HALTED
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [TYPEW-1:0] T_BR  = '0;
    localparam logic [TYPEW-1:0] T_ALU = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_IMM = TYPEW'(2);
    localparam logic [TYPEW-1:0] T_MEM = TYPEW'(4);
    localparam logic [TYPEW-1:0] T_JMP = TYPEW'(6);
    localparam logic [OPW-1:0]   OP_MSB_ONLY = OPW'(1) << (OPW - 1);

    state_t state_q, state_d;

    // WB-side shadow, captured on leaving ID
    logic [1:0] sh_mxrb_q, sh_mxrb_d;
    logic       sh_wrb_q,  sh_wrb_d;
    logic [2:0] sh_wrf_q,  sh_wrf_d;
    logic       sh_store_q, sh_store_d;
    logic       sh_br_q,   sh_br_d;
    logic       sh_mem_q,  sh_mem_d;

    // EX-side controls, also captured on leaving ID; they drive the outputs
    // directly so they naturally hold their value after EX.
    logic [OPW-1:0] op_alu_q, op_alu_d;
    logic [2:0]     op_tf_q,  op_tf_d;
    logic           op_se_q,  op_se_d;
    logic           mxse_q,   mxse_d;

    // WB selects, loaded on entry to WB and held afterwards
    logic [1:0] mxrb_q, mxrb_d;
    logic       mxpc_q, mxpc_d;

    // Decode of the instruction currently presented
    logic [OPW-1:0] dec_op_alu;
    logic [2:0]     dec_op_tf, dec_wrf;
    logic [1:0]     dec_mxrb;
    logic           dec_op_se, dec_mxse, dec_wrb, dec_store, dec_br;

    always_comb begin
        dec_op_alu = op;
        dec_op_tf  = 3'b111;
        dec_op_se  = 1'b0;
        dec_mxse   = 1'b0;
        dec_mxrb   = 2'd0;
        dec_wrb    = 1'b0;
        dec_wrf    = 3'd0;
        dec_store  = 1'b0;
        dec_br     = 1'b0;
        if (instr_type == T_ALU) begin
            dec_wrb  = 1'b1;
            dec_mxrb = 2'd2;
            if (op == '1)                          dec_wrf = 3'd0;
            else if (op == OP_MSB_ONLY)            dec_wrf = 3'd1;
            else if (op[OPW-1:OPW-2] == 2'b01)     dec_wrf = 3'd3;
            else if (op[OPW-1:OPW-2] == 2'b00)     dec_wrf = 3'd4;
            else                                   dec_wrf = 3'd2;
        end else if (instr_type == T_IMM) begin
            dec_op_se = 1'b1;
            dec_mxse  = 1'b1;
            dec_wrb   = 1'b1;
            dec_mxrb  = 2'd2;
        end else if (instr_type == T_MEM) begin
            if (op[OPW-1]) begin
                dec_store = 1'b1;
            end else begin
                dec_wrb  = 1'b1;
                dec_mxrb = 2'd1;
            end
        end else if (instr_type == T_BR || instr_type == T_JMP) begin
            dec_op_alu = ALU_PASS;
            dec_op_tf  = {op[2], op[3], op[4]};
            dec_br     = 1'b1;
            if (instr_type == T_BR) dec_mxse = 1'b1;
            else                    dec_wrb  = ({op[2], op[3], op[4]} == 3'b011);
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_mxrb_d  = sh_mxrb_q;
        sh_wrb_d   = sh_wrb_q;
        sh_wrf_d   = sh_wrf_q;
        sh_store_d = sh_store_q;
        sh_br_d    = sh_br_q;
        sh_mem_d   = sh_mem_q;
        op_alu_d   = op_alu_q;
        op_tf_d    = op_tf_q;
        op_se_d    = op_se_q;
        mxse_d     = mxse_q;
        mxrb_d     = mxrb_q;
        mxpc_d     = mxpc_q;

        case (state_q)
            S_IF:    if (IM_READY) state_d = S_ID;
            S_ID:    state_d = (instr_type == '1) ? S_HALT : S_EX;
            S_EX:    state_d = sh_mem_q ? S_MEM : S_WB;
            S_MEM:   if (DM_READY) state_d = S_WB;
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase

        // Stall overrides every transition; HALT is sticky anyway.
        if (STALL && state_q != S_HALT) state_d = state_q;

        if (state_q == S_ID && state_d != S_ID) begin
            sh_mxrb_d  = dec_mxrb;
            sh_wrb_d   = dec_wrb;
            sh_wrf_d   = dec_wrf;
            sh_store_d = dec_store;
            sh_br_d    = dec_br;
            sh_mem_d   = (instr_type == T_MEM);
            op_alu_d   = dec_op_alu;
            op_tf_d    = dec_op_tf;
            op_se_d    = dec_op_se;
            mxse_d     = dec_mxse;
        end

        // Branches always reach WB straight from EX, so TAKEN here is the
        // value present in the last EX cycle.
        if (state_d == S_WB && state_q != S_WB) begin
            mxrb_d = sh_mxrb_q;
            mxpc_d = sh_br_q & TAKEN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IF;
            sh_mxrb_q  <= '0;
            sh_wrb_q   <= 1'b0;
            sh_wrf_q   <= '0;
            sh_store_q <= 1'b0;
            sh_br_q    <= 1'b0;
            sh_mem_q   <= 1'b0;
            op_alu_q   <= '0;
            op_tf_q    <= '0;
            op_se_q    <= 1'b0;
            mxse_q     <= 1'b0;
            mxrb_q     <= '0;
            mxpc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_mxrb_q  <= sh_mxrb_d;
            sh_wrb_q   <= sh_wrb_d;
            sh_wrf_q   <= sh_wrf_d;
            sh_store_q <= sh_store_d;
            sh_br_q    <= sh_br_d;
            sh_mem_q   <= sh_mem_d;
            op_alu_q   <= op_alu_d;
            op_tf_q    <= op_tf_d;
            op_se_q    <= op_se_d;
            mxse_q     <= mxse_d;
            mxrb_q     <= mxrb_d;
            mxpc_q     <= mxpc_d;
        end
    end

    assign OP_ALU  = op_alu_q;
    assign OP_TF   = op_tf_q;
    assign OP_SE   = op_se_q;
    assign S_MXSE  = mxse_q;
    assign S_MXRB  = mxrb_q;
    assign S_MXPC  = mxpc_q;
    // State sits in IF during reset; gate so every output reads 0 then.
    assign W_IM    = RESET_N && (state_q == S_IF);
    assign W_DM    = (state_q == S_MEM) && sh_store_q;
    assign W_RB    = (state_q == S_WB) && sh_wrb_q;
    assign W_PC    = (state_q == S_WB);
    assign W_RF    = (state_q == S_WB) ? sh_wrf_q : 3'd0;
    assign STATE_O = state_q;
    assign HALTED  = (state_q == S_HALT);

endmodule

// File: tb/tb_unit_control_mc.sv
module tb_unit_control_mc;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [2:0] instr_type;
    logic [4:0] op;
    logic       IM_READY, DM_READY, STALL, TAKEN;
    logic [4:0] OP_ALU;
    logic [2:0] OP_TF;
    logic       OP_SE, S_MXSE;
    logic [1:0] S_MXRB;
    logic       S_MXPC, W_IM, W_DM, W_RB, W_PC;
    logic [2:0] W_RF, STATE_O;
    logic       HALTED;

    int n_chk = 0;
    int n_err = 0;

    unit_control_mc dut (
        .CLK(CLK), .RESET_N(RESET_N), .instr_type(instr_type), .op(op),
        .IM_READY(IM_READY), .DM_READY(DM_READY), .STALL(STALL), .TAKEN(TAKEN),
        .OP_ALU(OP_ALU), .OP_TF(OP_TF), .OP_SE(OP_SE), .S_MXSE(S_MXSE),
        .S_MXRB(S_MXRB), .S_MXPC(S_MXPC), .W_IM(W_IM), .W_DM(W_DM),
        .W_RB(W_RB), .W_PC(W_PC), .W_RF(W_RF), .STATE_O(STATE_O), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    task tick;
        @(posedge CLK);
        #1;
    endtask

    task test_reset;
        RESET_N = 1'b0; instr_type = 3'd0; op = 5'd0;
        IM_READY = 1'b0; DM_READY = 1'b0; STALL = 1'b0; TAKEN = 1'b0;
        #3;
        n_chk++; if (STATE_O !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d exp 0", STATE_O); end
        n_chk++; if (W_IM !== 1'b0) begin n_err++; $display("FAIL rst_w_im: got %0b exp 0", W_IM); end
        n_chk++; if (HALTED !== 1'b0 || OP_ALU !== 5'd0 || W_PC !== 1'b0) begin n_err++;
            $display("FAIL rst_outs: got halted=%0b op_alu=%0h w_pc=%0b exp 0,0,0", HALTED, OP_ALU, W_PC); end
        tick;
        RESET_N = 1'b1;
        #1;
        n_chk++; if (W_IM !== 1'b1 || STATE_O !== 3'd0) begin n_err++;
            $display("FAIL rst_release: got w_im=%0b state=%0d exp 1,0", W_IM, STATE_O); end
    endtask

    task test_alu_reg;
        instr_type = 3'b001; op = 5'b11111; IM_READY = 1'b1; DM_READY = 1'b1;
        tick;
        n_chk++; if (STATE_O !== 3'd1) begin n_err++; $display("FAIL alu_id: got %0d exp 1", STATE_O); end
        tick;
        n_chk++; if (STATE_O !== 3'd2 || OP_ALU !== 5'h1F || OP_TF !== 3'b111 || OP_SE !== 1'b0 || S_MXSE !== 1'b0 || W_RB !== 1'b0) begin n_err++;
            $display("FAIL alu_ex: got st=%0d alu=%0h tf=%0b se=%0b mxse=%0b wrb=%0b exp 2,1f,111,0,0,0", STATE_O, OP_ALU, OP_TF, OP_SE, S_MXSE, W_RB); end
        tick;
        n_chk++; if (STATE_O !== 3'd4 || W_RB !== 1'b1 || W_RF !== 3'd0 || S_MXRB !== 2'd2 || W_PC !== 1'b1) begin n_err++;
            $display("FAIL alu_wb: got st=%0d wrb=%0b wrf=%0d mxrb=%0d wpc=%0b exp 4,1,0,2,1", STATE_O, W_RB, W_RF, S_MXRB, W_PC); end
        tick;
        n_chk++; if (STATE_O !== 3'd0 || W_PC !== 1'b0 || W_RB !== 1'b0 || W_IM !== 1'b1 || S_MXRB !== 2'd2 || OP_ALU !== 5'h1F) begin n_err++;
            $display("FAIL alu_after: got st=%0d wpc=%0b wrb=%0b wim=%0b mxrb=%0d alu=%0h exp 0,0,0,1,2,1f", STATE_O, W_PC, W_RB, W_IM, S_MXRB, OP_ALU); end
    endtask

    task automatic test_wrf;
        logic [4:0] ops [5] = '{5'b10000, 5'b01010, 5'b00111, 5'b11000, 5'b10001};
        logic [2:0] exp [5] = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd2};
        for (int i = 0; i < 5; i++) begin
            instr_type = 3'b001; op = ops[i];
            tick; tick; tick;
            n_chk++; if (W_RF !== exp[i] || STATE_O !== 3'd4) begin n_err++;
                $display("FAIL wrf_%0d: got wrf=%0d st=%0d exp %0d,4", i, W_RF, STATE_O, exp[i]); end
            tick;
        end
    endtask

    task test_imm_stall;
        instr_type = 3'b010; op = 5'b00101; STALL = 1'b1;
        tick;
        n_chk++; if (STATE_O !== 3'd0 || W_IM !== 1'b1) begin n_err++;
            $display("FAIL stall_if: got st=%0d wim=%0b exp 0,1", STATE_O, W_IM); end
        STALL = 1'b0;
        tick; tick;
        n_chk++; if (STATE_O !== 3'd2 || OP_ALU !== 5'h05 || OP_SE !== 1'b1 || S_MXSE !== 1'b1 || OP_TF !== 3'b111) begin n_err++;
            $display("FAIL imm_ex: got st=%0d alu=%0h se=%0b mxse=%0b tf=%0b exp 2,05,1,1,111", STATE_O, OP_ALU, OP_SE, S_MXSE, OP_TF); end
        STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_chk++; if (STATE_O !== 3'd2 || OP_ALU !== 5'h05 || OP_SE !== 1'b1 || W_PC !== 1'b0 || W_RB !== 1'b0) begin n_err++;
                $display("FAIL stall_ex_%0d: got st=%0d alu=%0h se=%0b wpc=%0b wrb=%0b exp 2,05,1,0,0", i, STATE_O, OP_ALU, OP_SE, W_PC, W_RB); end
        end
        STALL = 1'b0;
        tick;
        n_chk++; if (STATE_O !== 3'd4 || W_RB !== 1'b1 || W_RF !== 3'd0 || S_MXRB !== 2'd2 || W_PC !== 1'b1) begin n_err++;
            $display("FAIL imm_wb: got st=%0d wrb=%0b wrf=%0d mxrb=%0d wpc=%0b exp 4,1,0,2,1", STATE_O, W_RB, W_RF, S_MXRB, W_PC); end
        tick;
    endtask

    task test_store;
        int n_dm;
        n_dm = 0;
        instr_type = 3'b100; op = 5'b10000; DM_READY = 1'b0;
        tick; tick;
        n_chk++; if (STATE_O !== 3'd2 || W_DM !== 1'b0) begin n_err++;
            $display("FAIL st_ex: got st=%0d wdm=%0b exp 2,0", STATE_O, W_DM); end
        for (int i = 0; i < 4; i++) begin
            tick;
            if (i == 3) DM_READY = 1'b1;
            if (STATE_O == 3'd3 && W_DM == 1'b1 && W_RB == 1'b0) n_dm++;
        end
        n_chk++; if (n_dm !== 4) begin n_err++; $display("FAIL st_mem_cycles: got %0d exp 4", n_dm); end
        tick;
        n_chk++; if (STATE_O !== 3'd4 || W_DM !== 1'b0 || W_RB !== 1'b0 || W_PC !== 1'b1 || W_RF !== 3'd0) begin n_err++;
            $display("FAIL st_wb: got st=%0d wdm=%0b wrb=%0b wpc=%0b wrf=%0d exp 4,0,0,1,0", STATE_O, W_DM, W_RB, W_PC, W_RF); end
        tick;
    endtask

    task test_load;
        instr_type = 3'b100; op = 5'b00000; DM_READY = 1'b1;
        tick; tick; tick;
        n_chk++; if (STATE_O !== 3'd3 || W_DM !== 1'b0) begin n_err++;
            $display("FAIL ld_mem: got st=%0d wdm=%0b exp 3,0", STATE_O, W_DM); end
        tick;
        n_chk++; if (STATE_O !== 3'd4 || W_RB !== 1'b1 || S_MXRB !== 2'd1 || W_RF !== 3'd0) begin n_err++;
            $display("FAIL ld_wb: got st=%0d wrb=%0b mxrb=%0d wrf=%0d exp 4,1,1,0", STATE_O, W_RB, S_MXRB, W_RF); end
        tick;
    endtask

    task test_branch;
        instr_type = 3'b000; op = 5'b01100; TAKEN = 1'b1;
        tick; tick;
        n_chk++; if (OP_TF !== 3'b110 || OP_ALU !== 5'b10011 || S_MXSE !== 1'b1) begin n_err++;
            $display("FAIL br_ex: got tf=%0b alu=%0b mxse=%0b exp 110,10011,1", OP_TF, OP_ALU, S_MXSE); end
        tick;
        n_chk++; if (STATE_O !== 3'd4 || S_MXPC !== 1'b1 || W_RB !== 1'b0 || W_RF !== 3'd0 || W_PC !== 1'b1) begin n_err++;
            $display("FAIL br_wb: got st=%0d mxpc=%0b wrb=%0b wrf=%0d wpc=%0b exp 4,1,0,0,1", STATE_O, S_MXPC, W_RB, W_RF, W_PC); end
        tick;
        TAKEN = 1'b0;
    endtask

    task test_nop;
        instr_type = 3'b011; op = 5'b11111; TAKEN = 1'b1;
        tick; tick; tick;
        n_chk++; if (STATE_O !== 3'd4 || W_RB !== 1'b0 || W_RF !== 3'd0 || W_PC !== 1'b1 || S_MXPC !== 1'b0 || W_DM !== 1'b0) begin n_err++;
            $display("FAIL nop_wb: got st=%0d wrb=%0b wrf=%0d wpc=%0b mxpc=%0b wdm=%0b exp 4,0,0,1,0,0", STATE_O, W_RB, W_RF, W_PC, S_MXPC, W_DM); end
        tick;
        TAKEN = 1'b0;
    endtask

    task test_jump;
        instr_type = 3'b110; op = 5'b11000; TAKEN = 1'b0;
        tick; tick;
        n_chk++; if (OP_TF !== 3'b011 || S_MXSE !== 1'b0 || OP_ALU !== 5'b10011) begin n_err++;
            $display("FAIL jmp_ex: got tf=%0b mxse=%0b alu=%0b exp 011,0,10011", OP_TF, S_MXSE, OP_ALU); end
        tick;
        n_chk++; if (W_RB !== 1'b1 || S_MXRB !== 2'd0 || S_MXPC !== 1'b0 || W_PC !== 1'b1) begin n_err++;
            $display("FAIL jmp_wb: got wrb=%0b mxrb=%0d mxpc=%0b wpc=%0b exp 1,0,0,1", W_RB, S_MXRB, S_MXPC, W_PC); end
        tick;
    endtask

    task test_reset_mem;
        instr_type = 3'b100; op = 5'b10000; DM_READY = 1'b0;
        tick; tick; tick;
        n_chk++; if (STATE_O !== 3'd3 || W_DM !== 1'b1 || OP_ALU !== 5'b10000) begin n_err++;
            $display("FAIL rm_mem: got st=%0d wdm=%0b alu=%0h exp 3,1,10", STATE_O, W_DM, OP_ALU); end
        #3;
        RESET_N = 1'b0;
        #1;
        n_chk++; if (W_DM !== 1'b0 || STATE_O !== 3'd0 || W_IM !== 1'b0 || OP_ALU !== 5'd0 || OP_TF !== 3'd0 || S_MXSE !== 1'b0) begin n_err++;
            $display("FAIL rm_async: got wdm=%0b st=%0d wim=%0b alu=%0h tf=%0b mxse=%0b exp all 0", W_DM, STATE_O, W_IM, OP_ALU, OP_TF, S_MXSE); end
        RESET_N = 1'b1;
        DM_READY = 1'b1;
    endtask

    task test_halt;
        int n_h;
        n_h = 0;
        instr_type = 3'b111; op = 5'd0;
        tick; tick;
        n_chk++; if (HALTED !== 1'b1 || STATE_O !== 3'd5 || W_IM !== 1'b0) begin n_err++;
            $display("FAIL halt_enter: got halted=%0b st=%0d wim=%0b exp 1,5,0", HALTED, STATE_O, W_IM); end
        instr_type = 3'b001;
        for (int i = 0; i < 20; i++) begin
            STALL = (i % 3 == 0);
            tick;
            if (HALTED == 1'b1 && STATE_O == 3'd5 && W_IM == 1'b0 && W_PC == 1'b0 && W_RB == 1'b0) n_h++;
        end
        STALL = 1'b0;
        n_chk++; if (n_h !== 20) begin n_err++; $display("FAIL halt_persist: got %0d exp 20", n_h); end
        #2;
        RESET_N = 1'b0;
        #1;
        n_chk++; if (HALTED !== 1'b0 || STATE_O !== 3'd0) begin n_err++;
            $display("FAIL halt_reset: got halted=%0b st=%0d exp 0,0", HALTED, STATE_O); end
        RESET_N = 1'b1;
        #1;
        n_chk++; if (W_IM !== 1'b1) begin n_err++; $display("FAIL halt_release: got wim=%0b exp 1", W_IM); end
    endtask

    initial begin
        test_reset;
        test_alu_reg;
        test_wrf;
        test_imm_stall;
        test_store;
        test_load;
        test_branch;
        test_nop;
        test_jump;
        test_reset_mem;
        test_halt;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/unit_control_mc.md
UNIT_CONTROL_MC -- requirements
Module: unit_control_mc

Interface
REQ-001 SHALL have parameter OPW, default 5: width of op field and OP_ALU.
REQ-002 SHALL have parameter TYPEW, default 3: width of type field (minimum 3).
REQ-003 SHALL have parameter ALU_PASS, default 5'b10011: ALU opcode used for branch/jump, OPW bits wide.
REQ-004 SHALL have ports: CLK  in  1  clock, all state changes on rising edge.
REQ-005 SHALL have ports: RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: type  in  TYPEW  instruction class; op  in  OPW  instruction opcode.
REQ-007 SHALL have ports: IM_READY  in  1  instruction memory done; DM_READY  in  1  data memory done.
REQ-008 SHALL have ports: STALL  in  1  freeze request; TAKEN  in  1  flag-test result for branch.
REQ-009 SHALL have ports: OP_ALU  out  OPW; OP_TF  out  3; OP_SE  out  1; S_MXSE  out  1; S_MXRB  out  2; S_MXPC  out  1.
REQ-010 SHALL have ports: W_IM, W_DM, W_RB, W_PC  out  1 each, write strobes; W_RF  out  3  flag-write select.
REQ-011 SHALL have ports: STATE_O  out  3  current state code; HALTED  out  1  high in HALT.

Function
REQ-012 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to IF next cycle.
REQ-013 IF: W_IM=1; SHALL remain in IF until IM_READY=1, then go to ID.
REQ-014 ID: SHALL latch decoded controls (REQ-019..024) into shadow registers in one cycle; type all-ones SHALL go to HALT, else EX.
REQ-015 EX: SHALL drive OP_ALU, OP_TF, OP_SE, S_MXSE from shadow; memory class (type 100) SHALL go to MEM, else WB.
REQ-016 MEM: W_DM=1 for stores; SHALL remain until DM_READY=1, then go to WB.
REQ-017 WB: SHALL assert W_RB, W_RF, S_MXRB, S_MXPC from shadow and W_PC=1 for exactly one cycle, then go to IF.
REQ-018 Strobes W_IM, W_DM, W_RB, W_PC and W_RF SHALL be 0 outside their owning state; datapath selects SHALL hold last value.
REQ-019 type 001 (ALU reg): OP_ALU=op, OP_TF=3'b111, W_RB=1, S_MXRB=2, S_MXSE=0, OP_SE=0.
REQ-020 type 001 W_RF: op all-ones->0; op=1 followed by zeros->1; op[OPW-1:OPW-2]=01->3; =00->4; else 2.
REQ-021 type 010 (ALU imm): OP_ALU=op, OP_SE=1, S_MXSE=1, W_RB=1, S_MXRB=2, W_RF=0, OP_TF=3'b111.
REQ-022 type 100 (memory): op[OPW-1]=1 store (W_DM=1, W_RB=0), else load (W_RB=1, S_MXRB=1); W_RF=0, S_MXSE=0.
REQ-023 type 000 (branch): OP_ALU=ALU_PASS, OP_TF={op[2],op[3],op[4]}, S_MXSE=1, W_RB=0, W_RF=0; S_MXPC=TAKEN sampled in EX.
REQ-024 type 110 (jump): as branch but S_MXSE=0, S_MXRB=0, W_RB=1 iff decoded OP_TF of this instruction equals 3'b011.
REQ-025 any other non-halt type SHALL be a NOP: no register/memory/flag write, W_PC=1 in WB, S_MXPC=0.
REQ-026 STALL=1 SHALL freeze state and all outputs in any state except HALT; STALL SHALL take priority over IM_READY/DM_READY.
REQ-027 HALT SHALL be left only by reset; all strobes 0 while halted.
REQ-028 Instruction latency without stall/wait: 4 cycles (IF-ID-EX-WB), 5 for memory class.

Reset
REQ-029 RESET_N=0 SHALL immediately force state IF and all outputs 0 (including shadow registers), independent of CLK.
REQ-030 first rising edge after RESET_N deasserts SHALL evaluate IF with W_IM=1; reset mid-MEM SHALL abandon W_DM at once.

Verification
REQ-031 type=001, op=5'b11111, ready held high -> W_RB=1 and W_RF=0 in WB, 4th cycle after IF; W_PC pulse one cycle.
REQ-032 type=100, op=5'b10000, DM_READY low 3 cycles -> W_DM=1 for 4 cycles in MEM, W_RB=0, then WB.
REQ-033 type=000, op=5'b01100, TAKEN=1 in EX -> OP_TF=3'b110, OP_ALU=5'b10011, S_MXPC=1 in WB.
REQ-034 STALL=1 for 2 cycles during EX -> STATE_O stays 2, outputs unchanged; instruction completes 2 cycles late.
REQ-035 type=3'b111 -> HALTED=1 from cycle after ID, persists 20 cycles; RESET_N low pulse -> IF, HALTED=0.
REQ-036 RESET_N asserted between clock edges in MEM -> all outputs 0 before next edge.
